// File: rtl/rr_arbiter_n.sv
// ============================================================================
// Module      : rr_arbiter_n
// Description : N-requester round-robin arbiter with registered one-hot grant,
//               encoded grant index and debug pointer. Optional burst hold is
//               compiled in by defining RR_ARBITER_HOLD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_n #(
  parameter  int N         = 3,
  parameter  int MAX_BURST = 4,
  localparam int IDW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   i_req,
  output logic [N-1:0]   o_gnt,
  output logic [IDW-1:0] o_gnt_id,
  output logic           o_gnt_vld,
  output logic [IDW-1:0] o_ptr
);

  if ((N < 2) || (N > 16) || (MAX_BURST < 1)) begin : g_param_chk
    $error("rr_arbiter_n: N must be 2..16 and MAX_BURST >= 1");
  end

  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic           r_gnt_vld;
  logic [IDW-1:0] r_ptr;

  logic [N-1:0]   w_gnt_nxt;
  logic [IDW-1:0] w_id_nxt;
  logic           w_vld_nxt;
  logic [IDW-1:0] w_ptr_nxt;

  logic           w_win_vld;
  logic [IDW-1:0] w_win_id;
  int             w_idx;
  logic           w_hold;

  // Circular search from ptr+1 through ptr; the index is reduced modulo N so
  // non-power-of-two sizes never visit unused codes.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_id  = '0;
    w_idx     = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= N) begin
        w_idx = w_idx - N;
      end
      if (!w_win_vld && i_req[w_idx]) begin
        w_win_vld = 1'b1;
        w_win_id  = IDW'(w_idx);
      end
    end
  end

`ifdef RR_ARBITER_HOLD_EN
  localparam int BCW  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int BMAX = MAX_BURST - 1;

  logic [BCW-1:0] r_burst;
  logic [BCW-1:0] w_burst_nxt;
  logic           w_hold_req;
  logic           w_others;

  // The holder stays while its burst budget lasts, or indefinitely if alone.
  always_comb begin
    w_hold_req  = r_gnt_vld && (|(i_req & r_gnt));
    w_others    = |(i_req & ~r_gnt);
    w_hold      = w_hold_req && ((int'(r_burst) < BMAX) || !w_others);
    w_burst_nxt = r_burst;
    if (w_hold) begin
      if (int'(r_burst) < BMAX) begin
        w_burst_nxt = r_burst + 1'b1;
      end
    end else if (w_win_vld) begin
      w_burst_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_burst <= '0;
    end else begin
      r_burst <= w_burst_nxt;
    end
  end
`else
  assign w_hold = 1'b0;
`endif

  always_comb begin
    w_gnt_nxt = r_gnt;
    w_id_nxt  = r_gnt_id;
    w_vld_nxt = r_gnt_vld;
    w_ptr_nxt = r_ptr;
    if (w_hold) begin
      w_gnt_nxt = r_gnt;
    end else if (w_win_vld) begin
      w_gnt_nxt = N'(1) << w_win_id;
      w_id_nxt  = w_win_id;
      w_vld_nxt = 1'b1;
      w_ptr_nxt = w_win_id;
    end else begin
      w_gnt_nxt = '0;
      w_vld_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_gnt_vld <= 1'b0;
      r_ptr     <= IDW'(N - 1);
    end else begin
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_id_nxt;
      r_gnt_vld <= w_vld_nxt;
      r_ptr     <= w_ptr_nxt;
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_id  = r_gnt_id;
  assign o_gnt_vld = r_gnt_vld;
  assign o_ptr     = r_ptr;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter_n.sv
// ============================================================================
// Module      : tb_rr_arbiter_n
// Description : Self-checking scoreboard bench for rr_arbiter_n (N=3 and N=5).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter_n;

  localparam int MB = 4;
`ifdef RR_ARBITER_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [2:0] req3;
  logic [4:0] req5;
  logic [2:0] g3;
  logic [1:0] id3;
  logic       v3;
  logic [1:0] p3;
  logic [4:0] g5;
  logic [2:0] id5;
  logic       v5;
  logic [2:0] p5;

  rr_arbiter_n #(.N(3), .MAX_BURST(MB)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .i_req(req3),
    .o_gnt(g3), .o_gnt_id(id3), .o_gnt_vld(v3), .o_ptr(p3)
  );

  rr_arbiter_n #(.N(5), .MAX_BURST(MB)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .i_req(req5),
    .o_gnt(g5), .o_gnt_id(id5), .o_gnt_vld(v5), .o_ptr(p5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int gnt3; int id3; int vld3; int ptr3;
    int gnt5; int id5; int vld5; int ptr5;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  int m3_id, m3_ptr, m3_bc, m5_id, m5_ptr, m5_bc;
  bit m3_vld, m5_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference behaviour of one arbiter for one clock edge.
  task automatic mstep(input int n, input int r, inout int id, inout bit vld,
                       inout int ptr, inout int bc);
    bit keep;
    bit others;
    others = (r & ~(1 << id)) != 0;
    keep   = HOLD && vld && (((r >> id) & 1) != 0) && ((bc < MB - 1) || !others);
    if (keep) begin
      if (bc < MB - 1) bc++;
    end else begin
      vld = 1'b0;
      for (int k = 1; k <= n; k++) begin
        int c;
        c = (ptr + k) % n;
        if (!vld && (((r >> c) & 1) != 0)) begin
          id  = c;
          ptr = c;
          vld = 1'b1;
          bc  = 0;
        end
      end
    end
  endtask

  task automatic mreset();
    m3_id = 0; m3_vld = 1'b0; m3_ptr = 2; m3_bc = 0;
    m5_id = 0; m5_vld = 1'b0; m5_ptr = 4; m5_bc = 0;
  endtask

  task automatic step(input logic [2:0] r3, input logic [4:0] r5);
    exp_t e;
    req3 = r3;
    req5 = r5;
    mstep(3, int'(r3), m3_id, m3_vld, m3_ptr, m3_bc);
    mstep(5, int'(r5), m5_id, m5_vld, m5_ptr, m5_bc);
    e.gnt3 = m3_vld ? (1 << m3_id) : 0;
    e.id3  = m3_id; e.vld3 = int'(m3_vld); e.ptr3 = m3_ptr;
    e.gnt5 = m5_vld ? (1 << m5_id) : 0;
    e.id5  = m5_id; e.vld5 = int'(m5_vld); e.ptr5 = m5_ptr;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("gnt3", 32'(g3), e.gnt3);
    check("id3",  32'(id3), e.id3);
    check("vld3", 32'(v3), e.vld3);
    check("ptr3", 32'(p3), e.ptr3);
    check("gnt5", 32'(g5), e.gnt5);
    check("id5",  32'(id5), e.id5);
    check("vld5", 32'(v5), e.vld5);
    check("ptr5", 32'(p5), e.ptr5);
    check("ptr5_range", 32'(p5 < 3'd5), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req3  = 3'b111;
    req5  = 5'b11111;
    mreset();
    @(posedge clk);
    #1;
    check("rst_gnt", 32'(g3), 0);
    check("rst_vld", 32'(v3), 0);
    check("rst_id",  32'(id3), 0);
    check("rst_ptr", 32'(p3), 2);
    check("rst_ptr5", 32'(p5), 4);
    rst_n = 1'b1;

    step(3'b100, 5'b00000);
    check("first_gnt", 32'(g3), 3'b100);
    check("first_id",  32'(id3), 2);

    for (int i = 0; i < 10; i++) begin
      step(3'b010, 5'b00000);
      check("sole_gnt", 32'(g3), 3'b010);
    end

    do_reset();
    for (int i = 0; i < 13; i++) begin
      int fl;
      if (HOLD) fl = (i < 4) ? 1 : (i < 8) ? 2 : (i < 12) ? 4 : 1;
      else      fl = 1 << (i % 3);
      step(3'b111, 5'b00000);
      check("full_gnt", 32'(g3), fl);
    end

    do_reset();
    step(3'b111, 5'b00000);
    step(3'b111, 5'b00000);
    step(3'b111, 5'b00000);
    step(3'b110, 5'b00000);
    check("early_gnt", 32'(g3), 3'b010);
    step(3'b000, 5'b00000);
    check("idle_gnt", 32'(g3), 0);
    check("idle_vld", 32'(v3), 0);
    check("idle_ptr", 32'(p3), 1);

    do_reset();
    step(3'b000, 5'b10001);
    check("wrap_first", 32'(g5), 5'b00001);
    for (int j = 1; j <= MB; j++) begin
      step(3'b000, 5'b10001);
      if (j == (HOLD ? MB : 1)) check("wrap_second", 32'(g5), 5'b10000);
    end

    do_reset();
    step(3'b111, 5'b00000);
    step(3'b111, 5'b00000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_gnt", 32'(g3), 0);
    check("async_vld", 32'(v3), 0);
    check("async_id",  32'(id3), 0);
    check("async_ptr", 32'(p3), 2);
    mreset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b110, 5'b00000);
    check("post_rst_gnt", 32'(g3), 3'b010);

    for (int i = 0; i < 60; i++) begin
      step(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
